muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer between the CPU control unit and the shared multiply and divide datapath units. Accepts one MULT/DIV request at a time, latches the operands, and holds the selected unit's init line until that unit reports completion. Captures the 64-bit result into the architectural HI/LO registers and gives the control unit a busy/stall indication and a one-cycle done pulse. Handles divide-by-zero without starting the divider and, optionally, aborts a unit that never completes.

## Interface
- TIMEOUT_CYCLES, 40, maximum cycles in a RUN state before abort (1..255); used only with timeout enabled
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op_start  in  1  request strobe from control unit; sampled only in IDLE
- op_sel  in  1  0 = MULT, 1 = DIV
- op_a, op_b  in  32 each  operands (multiplicand/dividend, multiplier/divisor)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; HI/LO final for this request
- div_zero  out  1  sticky flag, set by a DIV with op_b == 0
- timeout_err  out  1  sticky flag, set on abort
- hi, lo  out  32 each  architectural HI/LO registers
- mult_init, div_init  out  1 each  unit enables, held high while the unit runs
- unit_a, unit_b  out  32 each  latched operands, shared by both units, stable while either init is high
- mult_stop, div_stop  in  1 each  unit completion indications
- mult_hi, mult_lo, div_hi, div_lo  in  32 each  unit results; valid in the cycle the matching stop is high

## Operation
- States: IDLE, RUN_MULT, RUN_DIV, RELEASE.
- IDLE + op_start:
  - latch op_a/op_b into unit_a/unit_b
  - clear div_zero and timeout_err
  - op_sel = 0 → RUN_MULT
  - op_sel = 1 and op_b != 0 → RUN_DIV
  - op_sel = 1 and op_b == 0 → set div_zero, leave HI/LO unchanged, go to RELEASE
- RUN_MULT: mult_init = 1. When mult_stop = 1, hi ← mult_hi and lo ← mult_lo, then go to RELEASE. RUN_DIV is identical, using div_init, div_stop, div_hi and div_lo.
- RELEASE: both inits low, done = 1, next state IDLE. This guarantees each init is low for at least one cycle between operations.
- A stop input is ignored unless its own RUN state is active. The other unit's stop is always ignored.
- op_start outside IDLE is dropped, not queued. The control unit must stall on busy.
- mult_init and div_init are never high at the same time.
- At most one HI/LO write per request. HI/LO change only in the cycle after a valid stop is seen.
- Reset values: every output 0, HI/LO 0, state IDLE, cycle counter 0.
- Reset mid-operation: the next edge forces IDLE with inits low. No done pulse is issued and HI/LO are cleared.

## Timing
- op_start accepted at edge N. busy and init are high from cycle N+1.
- First cycle with stop high, edge M (M ≥ N+1): HI/LO are updated and state is RELEASE from cycle M+1. done is high in cycle M+1 only.
- busy falls in cycle M+2. The earliest next accepted op_start is at edge M+2.
- Divide-by-zero: done and div_zero are high in cycle N+1. busy falls in cycle N+2.
- Controller overhead is 2 cycles on top of the unit's own latency.

## Configuration
- MULDIV_TIMEOUT_EN defined:
  - an 8-bit counter clears on entry to a RUN state and increments each cycle in that state
  - if it reaches TIMEOUT_CYCLES with no stop seen, drop init, set timeout_err, leave HI/LO unchanged, go to RELEASE (done pulses)
  - if stop and the timeout occur in the same cycle, stop wins
- MULDIV_TIMEOUT_EN undefined:
  - no counter is built and timeout_err is tied to 0
  - RUN states wait indefinitely for their stop

## Test plan
- MULT with op_a = 7, op_b = −3 (0xFFFFFFFD); behavioural unit raises mult_stop 33 cycles after init → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, single done pulse, busy low 2 cycles after stop.
- DIV with op_a = 100, op_b = 0 → div_init never rises; div_zero = 1 and done = 1 in cycle N+1; HI/LO keep their prior values; the next op_start clears div_zero.
- op_start pulsed every cycle during a MULT → exactly one operation executes; unit_a/unit_b do not change while mult_init is high.
- reset asserted 10 cycles into a DIV → next cycle: state IDLE, div_init = 0, hi = lo = 0, done never pulses; a fresh DIV (100/7) then completes with lo = 14, hi = 2.
- MULDIV_TIMEOUT_EN with TIMEOUT_CYCLES = 40 and mult_stop held low → mult_init falls after 40 cycles in RUN; timeout_err = 1; done pulses once; HI/LO are unchanged.
- Spurious div_stop pulse during RUN_MULT → ignored; HI/LO take the mult results only.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT/DIV request through the shared multiply/divide units into HI/LO.
// Latency: unit latency + 2 cycles (done in the cycle after stop, idle the cycle after that); DIV by zero finishes in 1.
// Backpressure: busy is high while a request is in flight; op_start seen outside IDLE is dropped, never queued.
// Option: define MULDIV_TIMEOUT_EN to abort a unit that stays in RUN for TIMEOUT_CYCLES cycles without stopping.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  // request side
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout_err,
  output logic [31:0] hi,
  output logic [31:0] lo,
  // datapath unit side
  output logic        mult_init,
  output logic        div_init,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        mult_stop,
  input  logic        div_stop,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN_MULT = 2'd1;
  localparam logic [1:0] ST_RUN_DIV  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // The timeout counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range_bad
    $error("muldiv_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] ua_q, ua_d;
  logic [31:0] ub_q, ub_d;
  logic        dz_q, dz_d;
  logic        abort;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;

  // Counter holds the number of completed RUN cycles; abort on the last permitted one
  // so the unit's init line is high for exactly TIMEOUT_CYCLES cycles.
  assign abort = (cnt_q == TMO_LAST);
`else
  assign abort = 1'b0;
`endif

  // Next-state and register-update decisions for the request sequencer.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    dz_d    = dz_q;
`ifdef MULDIV_TIMEOUT_EN
    to_d    = to_q;
    cnt_d   = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          // Operands are frozen here and stay stable for the whole unit run.
          ua_d = op_a;
          ub_d = op_b;
          dz_d = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
          to_d = 1'b0;
`endif
          if (!op_sel) begin
            state_d = ST_RUN_MULT;
          end else if (op_b == 32'd0) begin
            // Divider is never started for a zero divisor; HI/LO keep their value.
            dz_d    = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_RUN_DIV;
          end
        end
      end
      ST_RUN_MULT: begin
`ifdef MULDIV_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // A stop arriving together with the timeout still delivers its result.
        if (mult_stop) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          state_d = ST_RELEASE;
        end else if (abort) begin
`ifdef MULDIV_TIMEOUT_EN
          to_d    = 1'b1;
`endif
          state_d = ST_RELEASE;
        end
      end
      ST_RUN_DIV: begin
`ifdef MULDIV_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (div_stop) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          state_d = ST_RELEASE;
        end else if (abort) begin
`ifdef MULDIV_TIMEOUT_EN
          to_d    = 1'b1;
`endif
          state_d = ST_RELEASE;
        end
      end
      default: begin
        // RELEASE: one cycle with both inits low so a unit always sees init drop between ops.
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and architectural register storage; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      ua_q    <= 32'd0;
      ub_q    <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      dz_q    <= dz_d;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  // Run-length counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_err = to_q;
`else
  assign timeout_err = 1'b0;
`endif

  // All outputs decode directly from registered state, so they are glitch-free.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_RELEASE);
  assign mult_init = (state_q == ST_RUN_MULT);
  assign div_init  = (state_q == ST_RUN_DIV);
  assign div_zero  = dz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign unit_a    = ua_q;
  assign unit_b    = ub_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start, op_sel;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero, timeout_err;
  logic [31:0] hi, lo, unit_a, unit_b;
  logic        mult_init, div_init, mult_stop, div_stop;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  muldiv_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .op_start(op_start), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout_err(timeout_err),
    .hi(hi), .lo(lo),
    .mult_init(mult_init), .div_init(div_init), .unit_a(unit_a), .unit_b(unit_b),
    .mult_stop(mult_stop), .div_stop(div_stop),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural multiply / divide units ----------------
  int mult_lat = 33;
  int div_lat  = 34;
  bit mult_en  = 1'b1;
  bit div_en   = 1'b1;
  bit spur_div = 1'b0;
  int mcnt = 0;
  int dcnt = 0;

  always @(posedge clk) begin
    mcnt <= mult_init ? mcnt + 1 : 0;
    dcnt <= div_init ? dcnt + 1 : 0;
  end

  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;
  always_comb begin
    prod = $signed(unit_a) * $signed(unit_b);
    quo  = 32'sd0;
    rem  = 32'sd0;
    if (unit_b != 32'd0) begin
      quo = $signed(unit_a) / $signed(unit_b);
      rem = $signed(unit_a) % $signed(unit_b);
    end
  end

  assign mult_stop = mult_init && mult_en && (mcnt == mult_lat);
  assign mult_hi   = prod[63:32];
  assign mult_lo   = prod[31:0];
  assign div_stop  = (div_init && div_en && (dcnt == div_lat)) || spur_div;
  assign div_hi    = spur_div ? 32'hDEAD_BEEF : rem;
  assign div_lo    = spur_div ? 32'hBAD0_BAD0 : quo;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding request (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("done_hi", hi, mon_e.hi);
        chk("done_lo", lo, mon_e.lo);
        chk("done_div_zero", {31'd0, div_zero}, {31'd0, mon_e.dz});
        chk("done_timeout_err", {31'd0, timeout_err}, {31'd0, mon_e.to});
      end
    end
    if (!reset && mult_init && div_init) begin
      checks++;
      errors++;
      $display("FAIL init_exclusive: mult_init=1 div_init=1, expected at most one (t=%0t)", $time);
    end
  end

  // Drive one request; returns in cycle N+1 after the accepting edge N.
  task automatic issue(input logic sel, input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input logic eto);
    exp_t e;
    @(negedge clk);
    op_start = 1'b1;
    op_sel   = sel;
    op_a     = a;
    op_b     = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.to = eto;
      sb.push_back(e);
    end
    @(negedge clk);
    op_start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("mult_init_after_start", {31'd0, mult_init}, {31'd0, !sel});
    chk("div_init_after_start", {31'd0, div_init}, {31'd0, (sel && b != 32'd0)});
    chk("div_zero_after_start", {31'd0, div_zero}, {31'd0, (sel && b == 32'd0)});
    chk("timeout_err_after_start", {31'd0, timeout_err}, 32'd0);
    chk("unit_a_latched", unit_a, a);
    chk("unit_b_latched", unit_b, b);
  endtask

  // Wait (bounded) for done, check stop->done spacing, then busy low the next cycle.
  task automatic finish_op(input string name, input int max, input bit exp_stop);
    int n = 0;
    bit prev_stop = 1'b0;
    while (!done && n < max) begin
      prev_stop = (mult_stop && mult_init) || (div_stop && div_init);
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_wait: no done within %0d cycles", name, max);
    end else begin
      chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      if (exp_stop) chk({name, "_stop_then_done"}, {31'd0, prev_stop}, 32'd1);
    end
    @(negedge clk);
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({name, "_done_single"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset    = 1'b1;
    op_start = 1'b0;
    op_sel   = 1'b0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mult_init", {31'd0, mult_init}, 32'd0);
    chk("rst_div_init", {31'd0, div_init}, 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_unit_b", unit_b, 32'd0);
    reset = 1'b0;

    // MULT 7 * -3 = -21.
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    finish_op("mult", 60, 1'b1);

    // DIV 100 / 0: divider never started, HI/LO kept, done in N+1.
    issue(1'b1, 32'd100, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0);
    chk("dz_done_n1", {31'd0, done}, 32'd1);
    finish_op("divzero", 3, 1'b0);
    chk("dz_sticky", {31'd0, div_zero}, 32'd1);
    chk("dz_hi_kept", hi, 32'hFFFF_FFFF);
    chk("dz_lo_kept", lo, 32'hFFFF_FFEB);

    // op_start held every cycle during a MULT 5*6: one operation, operands frozen.
    @(negedge clk);
    op_start = 1'b1;
    op_sel   = 1'b0;
    op_a     = 32'd5;
    op_b     = 32'd6;
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd30; e.dz = 1'b0; e.to = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("flood_div_zero_cleared", {31'd0, div_zero}, 32'd0);
    n = 0;
    while (!done && n < 80) begin
      if (mult_init) begin
        chk("flood_unit_a", unit_a, 32'd5);
        chk("flood_unit_b", unit_b, 32'd6);
      end
      op_a   = 32'h1111_0000 + 32'(n);
      op_b   = ~op_a;
      op_sel = n[0];
      @(negedge clk);
      n++;
    end
    op_start = 1'b0;
    chk("flood_done_seen", {31'd0, done}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("flood_no_second_op", {31'd0, busy}, 32'd0);
    end

    // Spurious div_stop during a MULT 0x10000 * 0x30000 = 0x3_0000_0000.
    issue(1'b0, 32'h0001_0000, 32'h0003_0000, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    spur_div = 1'b1;
    @(negedge clk);
    spur_div = 1'b0;
    @(negedge clk);
    chk("spur_hi_unchanged", hi, 32'd0);
    chk("spur_lo_unchanged", lo, 32'd30);
    chk("spur_still_running", {31'd0, mult_init}, 32'd1);
    finish_op("spur_mult", 60, 1'b1);

    // Reset 10 cycles into a DIV: no done, HI/LO cleared.
    issue(1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    chk("rdiv_running", {31'd0, div_init}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rdiv_busy", {31'd0, busy}, 32'd0);
    chk("rdiv_div_init", {31'd0, div_init}, 32'd0);
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    chk("rdiv_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);

    // Fresh DIV 100 / 7: quotient 14 in LO, remainder 2 in HI.
    issue(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 1'b0);
    finish_op("div", 60, 1'b1);

`ifdef MULDIV_TIMEOUT_EN
    // Multiplier never stops: abort after TMO RUN cycles, HI/LO unchanged.
    mult_en = 1'b0;
    issue(1'b0, 32'd9, 32'd9, 1'b1, 32'd2, 32'd14, 1'b0, 1'b1);
    n = 0;
    while (mult_init && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_init_cycles", 32'(n), 32'(TMO));
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("tmo_busy_low", {31'd0, busy}, 32'd0);
    mult_en = 1'b1;
    issue(1'b0, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0, 1'b0);
    finish_op("after_tmo", 60, 1'b1);
`else
    // Without the timeout a slow unit is simply waited for.
    mult_lat = 100;
    issue(1'b0, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0, 1'b0);
    finish_op("slow_mult", 200, 1'b1);
    mult_lat = 33;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
